ide_pio_seq: RTL

IDE_PIO_SEQ -- requirements
Module: ide_pio_seq

---
 rtl/ide_pio_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ide_pio_seq.sv
// IDE PIO cycle sequencer: sequences one programmed-I/O register access through
// setup, strobe, hold and recovery phases with per-phase cycle counts.
module ide_pio_seq #(
   parameter int T_SETUP  = 3,
   parameter int T_ACTIVE = 8,
   parameter int T_HOLD   = 2,
   parameter int T_RECOV  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        wr,
   input  logic [4:0]  addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [15:0] rdata,
   input  logic [15:0] ide_data_in,
   output logic [15:0] ide_data_out,
   output logic        ide_data_oe,
   output logic        ide_dior,
   output logic        ide_diow,
   output logic [1:0]  ide_cs,
   output logic [2:0]  ide_da
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACTIVE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Counter reload values: each phase counts down to zero, so load length-1.
   localparam logic [3:0] LD_SETUP  = 4'(T_SETUP - 1);
   localparam logic [3:0] LD_ACTIVE = 4'(T_ACTIVE - 1);
   localparam logic [3:0] LD_HOLD   = 4'(T_HOLD - 1);
   localparam logic [3:0] LD_RECOV  = 4'(T_RECOV - 1);

   state_t      state_r, state_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        wr_r, wr_s;
   logic [4:0]  addr_r, addr_s;
   logic [15:0] wdata_r, wdata_s;
   logic        accept_s;
   logic        bus_s;

   logic        ready_r, done_r, oe_r, dior_r, diow_r;
   logic [1:0]  cs_r;
   logic [2:0]  da_r;
   logic [15:0] dout_r, rdata_r;

   // Next-state, phase counter and latched-request selection.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               accept_s = 1'b1;
               state_s  = ST_SETUP;
               cnt_s    = LD_SETUP;
            end else begin
               cnt_s    = 4'd0;
            end
         end
         ST_SETUP: begin
            if (cnt_r == 4'd0) begin
               state_s = ST_ACTIVE;
               cnt_s   = LD_ACTIVE;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         ST_ACTIVE: begin
            if (cnt_r == 4'd0) begin
               state_s = ST_HOLD;
               cnt_s   = LD_HOLD;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_r == 4'd0) begin
               state_s = ST_RECOVER;
               cnt_s   = LD_RECOV;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_r == 4'd0) begin
               state_s = ST_IDLE;
               cnt_s   = 4'd0;
            end else begin
               cnt_s   = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase

      if (accept_s) begin
         wr_s    = wr;
         addr_s  = addr;
         wdata_s = wdata;
      end else begin
         wr_s    = wr_r;
         addr_s  = addr_r;
         wdata_s = wdata_r;
      end

      // Address/chip-select (and write data) stay valid from SETUP through HOLD.
      bus_s = (state_s == ST_SETUP) || (state_s == ST_ACTIVE) || (state_s == ST_HOLD);
   end

   // State, counter and request latches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         wr_r    <= 1'b0;
         addr_r  <= 5'd0;
         wdata_r <= 16'h0000;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         wr_r    <= wr_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
      end
   end

   // Bus and handshake outputs, registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         dior_r  <= 1'b1;
         diow_r  <= 1'b1;
         oe_r    <= 1'b0;
         cs_r    <= 2'b11;
         da_r    <= 3'd0;
         dout_r  <= 16'h0000;
      end else begin
         ready_r <= (state_s == ST_IDLE);
         done_r  <= (state_s == ST_RECOVER) && (state_r == ST_HOLD);
         dior_r  <= !((state_s == ST_ACTIVE) && !wr_s);
         diow_r  <= !((state_s == ST_ACTIVE) && wr_s);
         oe_r    <= bus_s && wr_s;
         cs_r    <= bus_s ? addr_s[4:3] : 2'b11;
         da_r    <= bus_s ? addr_s[2:0] : 3'd0;
         dout_r  <= (bus_s && wr_s) ? wdata_s : 16'h0000;
      end
   end

   // Read data is sampled on the edge that closes the final strobe-low cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_r <= 16'h0000;
      end else if ((state_r == ST_ACTIVE) && (cnt_r == 4'd0) && !wr_r) begin
         rdata_r <= ide_data_in;
      end
   end

   assign ready        = ready_r;
   assign done         = done_r;
   assign rdata        = rdata_r;
   assign ide_data_out = dout_r;
   assign ide_data_oe  = oe_r;
   assign ide_dior     = dior_r;
   assign ide_diow     = diow_r;
   assign ide_cs       = cs_r;
   assign ide_da       = da_r;

endmodule
